// File: rtl/watch_cmd_scheduler.sv
// watch_cmd_scheduler: merges debounced button pulses and UART command bytes
// into 3-bit opcodes, queues them in a small FIFO and replays them as
// single-cycle action pulses with a fixed idle gap after each pulse.
//
// Handshake note: there is no backpressure toward the sources. Buttons and
// rx_valid are fire-and-forget strobes. A command that cannot be stored is
// dropped and recorded in the sticky ovf flag. The only exception is the
// UART hold register, which simply waits while the FIFO is full.
module watch_cmd_scheduler #(
   parameter int FIFO_DEPTH = 4,
   parameter int GAP_CYCLES = 2
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic                              watch_mod_sw,
   input  logic                              btn_u,
   input  logic                              btn_l,
   input  logic                              btn_r,
   input  logic                              btn_d,
   input  logic [7:0]                        rx_data,
   input  logic                              rx_valid,
   input  logic                              clr_ovf,
   output logic                              sw_run_stop,
   output logic                              sw_clear,
   output logic                              w_sec_add,
   output logic                              w_min_add,
   output logic                              w_hour_add,
   output logic                              busy,
   output logic                              ovf,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

   typedef enum logic [2:0] {
      OP_NONE    = 3'd0,
      OP_RUNSTOP = 3'd1,
      OP_CLEAR   = 3'd2,
      OP_ADDH    = 3'd3,
      OP_ADDM    = 3'd4,
      OP_ADDS    = 3'd5
   } op_e;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_GAP   = 2'd2
   } state_e;

   // registers
   state_e          state_q, state_d;
   op_e             op_q, op_d;
   logic [GW-1:0]   gap_q, gap_d;
   op_e             mem_q [FIFO_DEPTH];
   logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]   count_q, count_d;
   logic            hold_valid_q;
   op_e             hold_op_q;
   logic            ovf_q, ovf_d;
   logic            busy_q, busy_d;
   logic [4:0]      act_q, act_d;

   // decode / push / pop signals
   op_e             btn_op, rx_op, push_op;
   logic            fifo_full, fifo_empty;
   logic            btn_push, btn_drop, hold_push, rx_load, rx_drop;
   logic            push, pop;

   // Button decode: mode selects the meaning, priority l > r > u > d among
   // the buttons that are meaningful in the current mode.
   always_comb begin
      btn_op = OP_NONE;
      if (!watch_mod_sw) begin
         if (btn_l)      btn_op = OP_RUNSTOP;
         else if (btn_r) btn_op = OP_CLEAR;
      end else begin
         if (btn_l)      btn_op = OP_ADDM;
         else if (btn_u) btn_op = OP_ADDH;
         else if (btn_d) btn_op = OP_ADDS;
      end
   end

   // UART decode: case-insensitive command letters, anything else ignored.
   always_comb begin
      rx_op = OP_NONE;
      case (rx_data)
         8'h52, 8'h72: rx_op = OP_RUNSTOP; // R r
         8'h43, 8'h63: rx_op = OP_CLEAR;   // C c
         8'h48, 8'h68: rx_op = OP_ADDH;    // H h
         8'h4D, 8'h6D: rx_op = OP_ADDM;    // M m
         8'h53, 8'h73: rx_op = OP_ADDS;    // S s
         default:      rx_op = OP_NONE;
      endcase
   end

   // Push arbitration: button wins the single push slot; the hold register
   // retries until there is room, a button is simply dropped when full.
   always_comb begin
      fifo_full  = (count_q == CW'(FIFO_DEPTH));
      fifo_empty = (count_q == '0);
      btn_push   = (btn_op != OP_NONE) && !fifo_full;
      btn_drop   = (btn_op != OP_NONE) && fifo_full;
      hold_push  = (btn_op == OP_NONE) && hold_valid_q && !fifo_full;
      rx_load    = rx_valid && (rx_op != OP_NONE) && !hold_valid_q;
      rx_drop    = rx_valid && (rx_op != OP_NONE) && hold_valid_q;
      push       = btn_push || hold_push;
      push_op    = btn_push ? btn_op : hold_op_q;
      ovf_d      = (btn_drop || rx_drop) ? 1'b1 : (clr_ovf ? 1'b0 : ovf_q);
   end

   // FSM next state, pop request and registered-output next values.
   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      gap_d   = gap_q;
      pop     = 1'b0;
      act_d   = '0;
      case (state_q)
         S_IDLE: begin
            if (!fifo_empty) begin
               pop     = 1'b1;
               op_d    = mem_q[rd_ptr_q];
               state_d = S_ISSUE;
            end
         end
         S_ISSUE: begin
            gap_d   = GW'(GAP_CYCLES - 1);
            state_d = S_GAP;
         end
         S_GAP: begin
            if (gap_q == '0) state_d = S_IDLE;
            else             gap_d   = gap_q - 1'b1;
         end
         default: state_d = S_IDLE;
      endcase

      // The pulse register is loaded on entry to ISSUE so it is high
      // exactly during the ISSUE cycle.
      if (state_d == S_ISSUE) begin
         case (op_d)
            OP_RUNSTOP: act_d[0] = 1'b1;
            OP_CLEAR:   act_d[1] = 1'b1;
            OP_ADDS:    act_d[2] = 1'b1;
            OP_ADDM:    act_d[3] = 1'b1;
            OP_ADDH:    act_d[4] = 1'b1;
            default:    act_d    = '0;
         endcase
      end

      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase

      // busy covers the queued work plus the trailing cycle after the gap,
      // so the window spans first accept through the return to IDLE.
      busy_d = (count_d != '0) || (state_q != S_IDLE) || (state_d != S_IDLE);
   end

   // FSM, gap counter and registered outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         op_q    <= OP_NONE;
         gap_q   <= '0;
         act_q   <= '0;
         busy_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         gap_q   <= gap_d;
         act_q   <= act_d;
         busy_q  <= busy_d;
         ovf_q   <= ovf_d;
      end
   end

   // FIFO storage, pointers, occupancy and the UART hold register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= OP_NONE;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         hold_valid_q <= 1'b0;
         hold_op_q    <= OP_NONE;
      end else begin
         if (push) begin
            mem_q[wr_ptr_q] <= push_op;
            wr_ptr_q        <= wr_ptr_q + 1'b1;
         end
         if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
         count_q <= count_d;
         if (rx_load) begin
            hold_valid_q <= 1'b1;
            hold_op_q    <= rx_op;
         end else if (hold_push) begin
            hold_valid_q <= 1'b0;
         end
      end
   end

   assign sw_run_stop = act_q[0];
   assign sw_clear    = act_q[1];
   assign w_sec_add   = act_q[2];
   assign w_min_add   = act_q[3];
   assign w_hour_add  = act_q[4];
   assign busy        = busy_q;
   assign ovf         = ovf_q;
   assign fifo_count  = count_q;

endmodule

// File: doc/watch_cmd_scheduler.md
Name: watch_cmd_scheduler

Overview:
- Sequences all control actions for the stopwatch and watch counters. It merges debounced button pulses with UART command bytes, decodes them into opcodes, and queues them in a small FIFO.
- Opcodes are issued one at a time as single-cycle action pulses, with a guaranteed idle gap between pulses.
- Sits between the button debouncers / UART receiver and the stopwatch / watch counter blocks. It replaces ad-hoc OR-ing of button and UART pulses.

Parameters:
- FIFO_DEPTH, 4, command queue depth; power of 2, >= 2.
- GAP_CYCLES, 2, idle cycles forced after each issued pulse; >= 1.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- watch_mod_sw  input  1  0 = stopwatch mode, 1 = watch mode; used only for button decoding
- btn_u  input  1  debounced one-cycle pulse
- btn_l  input  1  debounced one-cycle pulse
- btn_r  input  1  debounced one-cycle pulse
- btn_d  input  1  debounced one-cycle pulse
- rx_data  input  8  UART received byte
- rx_valid  input  1  one-cycle strobe; rx_data is valid in the same cycle
- clr_ovf  input  1  clears the ovf flag
- sw_run_stop  output  1  one-cycle pulse to the stopwatch
- sw_clear  output  1  one-cycle pulse to the stopwatch
- w_sec_add  output  1  one-cycle pulse to the watch
- w_min_add  output  1  one-cycle pulse to the watch
- w_hour_add  output  1  one-cycle pulse to the watch
- busy  output  1  high when FSM is not IDLE or FIFO is non-empty
- ovf  output  1  sticky flag: a command was dropped
- fifo_count  output  $clog2(FIFO_DEPTH+1)  number of queued entries

Behaviour:
- Opcode encoding (3 bit): NONE=0, RUNSTOP=1, CLEAR=2, ADDH=3, ADDM=4, ADDS=5.
- Button decode, stopwatch mode (watch_mod_sw=0): btn_l -> RUNSTOP, btn_r -> CLEAR; btn_u and btn_d ignored.
- Button decode, watch mode (watch_mod_sw=1): btn_d -> ADDS, btn_l -> ADDM, btn_u -> ADDH; btn_r ignored.
- Simultaneous button pulses: only the highest priority is taken, priority l > r > u > d. The rest are discarded silently (no ovf).
- UART decode is mode-independent and case-insensitive: 'R'/'r' -> RUNSTOP, 'C'/'c' -> CLEAR, 'H'/'h' -> ADDH, 'M'/'m' -> ADDM, 'S'/'s' -> ADDS. Any other byte is ignored.
- UART hold register (1 entry):
  - On rx_valid with a recognised byte: if hold is empty, load it. If hold is full, drop the byte and set ovf.
- FIFO push: at most one push per cycle.
  - A decoded button opcode has priority over the hold register.
  - The hold register pushes in any cycle with no button push; the hold is emptied on that push.
  - A button push when the FIFO is full drops the opcode and sets ovf.
  - A hold register push when the FIFO is full does not occur; the entry stays in hold.
- Opcodes are decoded at enqueue time. A later watch_mod_sw change never reinterprets queued entries.
- FSM states:
  - IDLE: if FIFO is non-empty, pop the head into op_reg and go to ISSUE.
  - ISSUE: exactly one output pulse, selected by op_reg, is high for this cycle; load gap counter with GAP_CYCLES-1; go to GAP.
  - GAP: all outputs low; counter decrements; at 0 go to IDLE.
- Push and pop in the same cycle are allowed; fifo_count is unchanged.
- Pulse spacing: minimum spacing between output pulses is GAP_CYCLES+2 cycles (ISSUE + GAP_CYCLES + IDLE).
- Latency, button pulse in cycle t, FIFO empty, FSM in IDLE:
  - pushed at end of t; popped at end of t+1; output pulse in cycle t+2.
- Latency, UART strobe in cycle t, no contention:
  - hold loaded at end of t; pushed at end of t+1; output pulse in cycle t+3.
- All outputs are registered. At most one action output is high in any cycle.
- ovf is set on any drop. clr_ovf clears it. If a drop and clr_ovf occur in the same cycle, set wins.
- Reset, asynchronous, at any time including mid-ISSUE or mid-GAP:
  - FSM -> IDLE; FIFO and hold register emptied; fifo_count=0; ovf=0; busy=0; all action outputs 0.
  - The first pulse is possible 2 cycles after the first accepted input following reset deassertion.

Test Plan:
- watch_mod_sw=0, btn_l pulse at cycle 10 -> sw_run_stop high in cycle 12 only; busy high cycles 11-15 for GAP_CYCLES=2; all other outputs 0.
- watch_mod_sw=1, btn_d/btn_l/btn_u pulses in consecutive cycles 0,1,2 -> w_sec_add at 2, w_min_add at 6, w_hour_add at 10; fifo_count peaks at 2.
- rx_valid with 'r' and btn_r (mode 0) in the same cycle 0 -> sw_clear at cycle 2, sw_run_stop at cycle 6; hold pushes at end of cycle 1.
- Six button pulses back-to-back with FIFO_DEPTH=4 -> five pulses issued, one dropped, ovf=1; clr_ovf pulse -> ovf=0.
- rx_valid with 'x', then with 'Q' -> no push, no output, ovf stays 0; 'h' while mode=0 -> w_hour_add issued.
- reset asserted during GAP with 3 entries queued -> immediately fifo_count=0, busy=0, no further pulses after deassert.
